bin2bcd_seq_ctrl: RTL and testbench

//   Sequential binary-to-BCD converter controller: iterative shift-add-3 (double dabble), one bit per clock.

---
 rtl/bin2bcd_seq_ctrl.sv | 69 ++++++
 tb/tb_bin2bcd_seq_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq_ctrl.sv
// bin2bcd_seq_ctrl: sequential double-dabble binary-to-BCD converter, one bit per clock.
// Optional AUTO_SAMPLE_EN: also start a conversion when bin_in differs from the last captured value.
module bin2bcd_seq_ctrl #(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 4
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_N,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t              state_q;
  logic [WIDTH-1:0]    bin_q, bin_d;
  logic [4*DIGITS-1:0] scr_q, scr_adj, scr_d;
  logic [CW-1:0]       cnt_q;
  logic                trig;
  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    assign scr_adj[4*d +: 4] = (scr_q[4*d +: 4] >= 4'd5) ? scr_q[4*d +: 4] + 4'd3 : scr_q[4*d +: 4];
  end
  assign {scr_d, bin_d} = {scr_adj, bin_q} << 1;
`ifdef AUTO_SAMPLE_EN
  logic [WIDTH-1:0] last_bin_q;
  assign trig = start || (bin_in != last_bin_q);
  always_ff @(posedge CLOCK_50 or negedge RESET_N)
    if (!RESET_N) last_bin_q <= '0;
    else if (state_q == IDLE && trig) last_bin_q <= bin_in;
`else
  assign trig = start;
`endif
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      bin_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: if (trig) begin
          bin_q   <= bin_in;
          scr_q   <= '0;
          cnt_q   <= CW'(WIDTH);
          busy    <= 1'b1;
          state_q <= SHIFT;
        end
        SHIFT: begin
          bin_q <= bin_d;
          scr_q <= scr_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            bcd_out <= scr_d;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bin2bcd_seq_ctrl.sv
// tb_bin2bcd_seq_ctrl: randomized scoreboard bench; expected BCD from decimal arithmetic.
module tb_bin2bcd_seq_ctrl;
  localparam int WIDTH = 10, DIGITS = 4;
  logic CLOCK_50 = 1'b0, RESET_N = 1'b0, start = 1'b0;
  logic [WIDTH-1:0] bin_in = '0;
  logic busy, done;
  logic [4*DIGITS-1:0] bcd_out;
  int checks = 0, passes = 0;
  logic [4*DIGITS-1:0] exp_q[$];

  bin2bcd_seq_ctrl #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out));

  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic logic [4*DIGITS-1:0] model(input int v);
    logic [4*DIGITS-1:0] r = '0;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge CLOCK_50) if (RESET_N) begin
    if (busy && done) check("busy_done_overlap", 1, 0);
    if (done) begin
      if (exp_q.size() == 0) check("unexpected_done", bcd_out, 32'hffff_ffff);
      else check("bcd_result", bcd_out, exp_q.pop_front());
    end
  end

  task automatic convert(input int v, input bit hold);
    int nb = 0, t = 0;
    bin_in = WIDTH'(v);
    start = 1'b1;
    exp_q.push_back(model(v));
    while (!busy && t < 40) begin @(negedge CLOCK_50); t++; end
    if (!hold) start = 1'b0;
    while (!done && t < 80) begin
      if (busy) nb++;
      @(negedge CLOCK_50); t++;
    end
    check("busy_cycles", nb, WIDTH);
    check("done_seen", done, 1);
  endtask

  task automatic quiet(input string name, input int n);
    int act = 0;
    repeat (n) begin @(negedge CLOCK_50); if (busy || done) act++; end
    check(name, act, 0);
  endtask

  initial begin
    // Reset with random inputs
    for (int i = 0; i < 8; i++) begin
      @(negedge CLOCK_50);
      start = 1'($urandom); bin_in = WIDTH'($urandom);
      check("reset_outputs", {busy, done, bcd_out}, '0);
    end
    start = 1'b0; bin_in = '0;
    @(negedge CLOCK_50); RESET_N = 1'b1;
    quiet("idle_after_reset", 10);
    // Full-scale conversion with a start pulse
    convert(1023, 1'b0);
    check("bcd_1023", bcd_out, 16'h1023);
    // Back-to-back with start held high
    convert(0, 1'b1);
    convert(999, 1'b1);
    convert(7, 1'b0);
    check("bcd_7", bcd_out, 16'h0007);
    quiet("idle_after_b2b", 5);
    // Start and bin_in changes during SHIFT are ignored
    bin_in = 10'd345; start = 1'b1; exp_q.push_back(model(345));
    @(negedge CLOCK_50); start = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    bin_in = 10'd678; start = 1'b1;
    @(negedge CLOCK_50); start = 1'b0; bin_in = 10'd345;
    for (int t = 0; t < 30 && !done; t++) @(negedge CLOCK_50);
    check("bcd_345", bcd_out, 16'h0345);
    quiet("second_req_ignored", 20);
    // Reset abandons a conversion in flight
    bin_in = 10'd512; start = 1'b1;
    @(negedge CLOCK_50); start = 1'b0;
    repeat (4) @(negedge CLOCK_50);
    #2 RESET_N = 1'b0; bin_in = '0;
    #1 check("abort_outputs", {busy, done, bcd_out}, '0);
    @(negedge CLOCK_50); RESET_N = 1'b1;
    quiet("no_done_after_abort", 15);
    convert(512, 1'b0);
    check("bcd_512", bcd_out, 16'h0512);
    // Random conversions
    for (int i = 0; i < 20; i++) begin
      convert($urandom_range(0, (1 << WIDTH) - 1), 1'($urandom));
      start = 1'b0;
    end
    bin_in = dut.bin_in;
`ifdef AUTO_SAMPLE_EN
    quiet("auto_settle", 20);
    bin_in = '0; start = 1'b0; exp_q.push_back(model(0));
    for (int t = 0; t < 30 && !done; t++) @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    bin_in = 10'd512; exp_q.push_back(model(512));
    for (int t = 0; t < 30 && !done; t++) @(negedge CLOCK_50);
    check("auto_bcd_512", bcd_out, 16'h0512);
    quiet("auto_stable", 30);
`endif
    repeat (20) @(negedge CLOCK_50);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
